// File: rtl/duty_ramp.sv
// Slew-rate-limited duty setpoint generator: walks duty toward a handshaken target
// by at most STEP counts per ramp tick so the PDM driver never sees a step change.
module duty_ramp #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 50,
    parameter int STEP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] tgt,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic [7:0] duty,
    output logic       busy,
    output logic       done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [7:0]    STEP_V  = 8'(STEP);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t        state;
    logic [7:0]    target;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          tick;
    logic          up;
    logic [7:0]    diff;

    assign tgt_ready = !rst;
    assign accept    = tgt_valid && tgt_ready;
    assign tick      = en && (cnt == CNT_MAX);
    assign up        = target > duty;
    assign diff      = up ? (target - duty) : (duty - target);

    // Accept wins over a coincident tick and restarts the prescaler, so the first
    // step of a new target always lands a full tick period after it was taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            target <= 8'd0;
            cnt    <= '0;
            duty   <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                target <= tgt;
                cnt    <= '0;
                if (tgt != duty) begin
                    state <= RAMP;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick && state == RAMP) begin
                    // Clamping to target before stepping keeps duty from wrapping.
                    if (diff <= STEP_V) begin
                        duty  <= target;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (up) begin
                        duty <= duty + STEP_V;
                    end else begin
                        duty <= duty - STEP_V;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: a STEP=4 instance for the ramp cases and a
// STEP=255 instance for full-scale single-tick moves, both with DIV=10.
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] tgt;
    logic       tgt_valid;

    logic       ready4, busy4, done4;
    logic [7:0] duty4;
    logic       ready255, busy255, done255;
    logic [7:0] duty255;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        bit         r;
        bit         en;
        bit         acc;
        logic [7:0] tgt;
        int         cyc;
        logic [7:0] duty;
        bit         busy;
        bit         done;
        bit         ready;
    } vec_t;

    typedef struct {
        string      name;
        bit         sel;
        logic [7:0] duty;
        bit         busy;
        bit         done;
        bit         ready;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    duty_ramp #(.CLK_HZ(100), .TICK_HZ(10), .STEP(4)) dut (
        .clk(clk), .rst(rst), .en(en), .tgt(tgt), .tgt_valid(tgt_valid),
        .tgt_ready(ready4), .duty(duty4), .busy(busy4), .done(done4)
    );

    duty_ramp #(.CLK_HZ(100), .TICK_HZ(10), .STEP(255)) dut255 (
        .clk(clk), .rst(rst), .en(en), .tgt(tgt), .tgt_valid(tgt_valid),
        .tgt_ready(ready255), .duty(duty255), .busy(busy255), .done(done255)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(string name, bit r, bit e, bit acc, logic [7:0] t,
                                   int cyc, logic [7:0] d, bit b, bit dn, bit rdy);
        vec_t v;
        v.name = name; v.r = r; v.en = e; v.acc = acc; v.tgt = t; v.cyc = cyc;
        v.duty = d; v.busy = b; v.done = dn; v.ready = rdy;
        return v;
    endfunction

    // Leaves the bench 1 ns past the last rising edge, away from the active edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] d;
        logic       b, dn, r;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e  = sb.pop_front();
        d  = e.sel ? duty255  : duty4;
        b  = e.sel ? busy255  : busy4;
        dn = e.sel ? done255  : done4;
        r  = e.sel ? ready255 : ready4;
        if ({d, b, dn, r} !== {e.duty, e.busy, e.done, e.ready}) begin
            failures++;
            $display("[TB] FAIL %s: got duty=%0d busy=%b done=%b ready=%b, expected duty=%0d busy=%b done=%b ready=%b",
                     e.name, d, b, dn, r, e.duty, e.busy, e.done, e.ready);
        end
    endtask

    task automatic pushExp(input string name, input bit sel, input logic [7:0] d,
                           input bit b, input bit dn);
        exp_t e;
        e.name = name; e.sel = sel; e.duty = d; e.busy = b; e.done = dn; e.ready = !rst;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst       = v.r;
        en        = v.en;
        tgt       = v.tgt;
        tgt_valid = v.acc;
        e.name = v.name; e.sel = 1'b0; e.duty = v.duty; e.busy = v.busy;
        e.done = v.done; e.ready = v.ready;
        sb.push_back(e);
        step(1);
        tgt_valid = 1'b0;
        if (v.cyc > 1) step(v.cyc - 1);
        checkOutput();
    endtask

    task automatic runAndCheck(input string name, input bit sel, input int n,
                               input logic [7:0] d, input bit b, input bit dn);
        pushExp(name, sel, d, b, dn);
        step(n);
        checkOutput();
    endtask

    task automatic acceptTgt(input logic [7:0] t);
        tgt       = t;
        tgt_valid = 1'b1;
        step(1);
        tgt_valid = 1'b0;
    endtask

    task automatic resetPulse(input string name);
        rst = 1'b1;
        runAndCheck(name, 1'b0, 1, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        tgt       = 8'd0;
        tgt_valid = 1'b0;

        // Each row: drive for cyc edges (accept on the first), then compare.
        vecs.push_back(mkVec("reset",           1, 1, 0,  0,  2,  0, 0, 0, 0));
        vecs.push_back(mkVec("reset_release",   0, 1, 0,  0,  1,  0, 0, 0, 1));
        vecs.push_back(mkVec("up_accept",       0, 1, 1, 20,  1,  0, 1, 0, 1));
        vecs.push_back(mkVec("up_before_tick",  0, 1, 0,  0,  9,  0, 1, 0, 1));
        vecs.push_back(mkVec("up_4",            0, 1, 0,  0,  1,  4, 1, 0, 1));
        vecs.push_back(mkVec("up_8",            0, 1, 0,  0, 10,  8, 1, 0, 1));
        vecs.push_back(mkVec("up_12",           0, 1, 0,  0, 10, 12, 1, 0, 1));
        vecs.push_back(mkVec("up_16",           0, 1, 0,  0, 10, 16, 1, 0, 1));
        vecs.push_back(mkVec("up_20_done",      0, 1, 0,  0, 10, 20, 0, 1, 1));
        vecs.push_back(mkVec("up_done_clear",   0, 1, 0,  0,  1, 20, 0, 0, 1));
        vecs.push_back(mkVec("clamp_reset",     1, 1, 0,  0,  1,  0, 0, 0, 0));
        vecs.push_back(mkVec("clamp_4",         0, 1, 1, 10, 11,  4, 1, 0, 1));
        vecs.push_back(mkVec("clamp_8",         0, 1, 0,  0, 10,  8, 1, 0, 1));
        vecs.push_back(mkVec("clamp_10_done",   0, 1, 0,  0, 10, 10, 0, 1, 1));
        vecs.push_back(mkVec("down_6",          0, 1, 1,  0, 11,  6, 1, 0, 1));
        vecs.push_back(mkVec("down_2",          0, 1, 0,  0, 10,  2, 1, 0, 1));
        vecs.push_back(mkVec("down_0_done",     0, 1, 0,  0, 10,  0, 0, 1, 1));
        vecs.push_back(mkVec("down_done_clear", 0, 1, 0,  0,  1,  0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Full-scale moves on the STEP=255 instance.
        rst = 1'b1;
        runAndCheck("fs_reset", 1'b1, 1, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        acceptTgt(8'd255);
        runAndCheck("fs_pre_tick",   1'b1, 9, 8'd0,   1'b1, 1'b0);
        runAndCheck("fs_up_255",     1'b1, 1, 8'd255, 1'b0, 1'b1);
        runAndCheck("fs_done_clear", 1'b1, 1, 8'd255, 1'b0, 1'b0);
        acceptTgt(8'd0);
        runAndCheck("fs_down_0",     1'b1, 10, 8'd0,  1'b0, 1'b1);

        // Retarget on the same edge as a tick: the tick is dropped.
        resetPulse("rt_reset");
        acceptTgt(8'd40);
        runAndCheck("rt_4",  1'b0, 10, 8'd4,  1'b1, 1'b0);
        runAndCheck("rt_8",  1'b0, 10, 8'd8,  1'b1, 1'b0);
        runAndCheck("rt_12", 1'b0, 10, 8'd12, 1'b1, 1'b0);
        step(9);
        acceptTgt(8'd4);
        runAndCheck("rt_tick_dropped", 1'b0, 0,  8'd12, 1'b1, 1'b0);
        runAndCheck("rt_cnt_restart",  1'b0, 9,  8'd12, 1'b1, 1'b0);
        runAndCheck("rt_down_8",       1'b0, 1,  8'd8,  1'b1, 1'b0);
        runAndCheck("rt_down_4_done",  1'b0, 10, 8'd4,  1'b0, 1'b1);
        runAndCheck("rt_done_clear",   1'b0, 1,  8'd4,  1'b0, 1'b0);

        // Enable hold mid-prescale, then reset mid-ramp and an equal-duty accept.
        resetPulse("hold_reset");
        acceptTgt(8'd40);
        runAndCheck("hold_4", 1'b0, 10, 8'd4, 1'b1, 1'b0);
        runAndCheck("hold_8", 1'b0, 10, 8'd8, 1'b1, 1'b0);
        step(5);
        en = 1'b0;
        runAndCheck("hold_frozen", 1'b0, 25, 8'd8, 1'b1, 1'b0);
        en = 1'b1;
        runAndCheck("hold_resume_pre", 1'b0, 4,  8'd8,  1'b1, 1'b0);
        runAndCheck("hold_resume_12",  1'b0, 1,  8'd12, 1'b1, 1'b0);
        runAndCheck("hold_16",         1'b0, 10, 8'd16, 1'b1, 1'b0);
        resetPulse("mid_ramp_reset");
        acceptTgt(8'd16);
        runAndCheck("eq_ramp_16_done", 1'b0, 40, 8'd16, 1'b0, 1'b1);
        runAndCheck("eq_done_clear",   1'b0, 1,  8'd16, 1'b0, 1'b0);
        acceptTgt(8'd16);
        runAndCheck("eq_accept_idle",  1'b0, 0,  8'd16, 1'b0, 1'b0);
        runAndCheck("eq_no_done",      1'b0, 15, 8'd16, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
Name: duty_ramp

Overview:
- Slew-rate-limited duty setpoint generator that feeds the 8-bit duty input of the servo/motor PDM driver.
- Accepts a new target duty over a valid/ready handshake.
- Moves its duty output toward the target by at most STEP counts per ramp tick, so the motor never sees a step change.
- Ramp tick rate defaults to the servo frame rate (50 Hz).

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- TICK_HZ, 50, ramp step rate in Hz; DIV = CLK_HZ/TICK_HZ (integer; DIV >= 2).
- STEP, 1, maximum duty change per tick (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  ramp enable; low freezes the ramp.
- tgt  in  8  requested target duty.
- tgt_valid  in  1  tgt is valid this cycle.
- tgt_ready  out  1  block can accept tgt.
- duty  out  8  current slew-limited duty, to the PDM driver duty input.
- busy  out  1  high while duty != latched target (RAMP state).
- done  out  1  one-cycle pulse when duty reaches the target.

Behaviour:
- Reset values: all registered state clears one cycle after rst is sampled high.
  - Outputs: duty=0, busy=0, done=0.
  - Internal: target=0, prescaler=0, state IDLE.
- tgt_ready = !rst (combinational). Accept occurs when tgt_valid && tgt_ready at a rising edge.
- Prescaler:
  - Counts 0..DIV-1 while en=1 and holds while en=0.
  - tick = en && (cnt==DIV-1); cnt wraps to 0 on tick.
  - Any accept clears cnt to 0, so the first step lands DIV enabled cycles after accept.
- States: IDLE, RAMP.
- Accept (either state):
  - target <= tgt.
  - If tgt != duty: next state RAMP, busy <= 1.
  - Else: next state IDLE, busy <= 0, no done pulse.
  - Accept has priority over a coincident tick; that tick is dropped and duty is unchanged.
  - Acceptance is honoured regardless of en.
- RAMP, on tick without accept:
  - diff = |target - duty|, computed 8-bit unsigned with a direction bit.
  - If diff <= STEP: duty <= target, state IDLE, busy <= 0, done <= 1 for exactly one cycle.
  - Else: duty <= duty + STEP (target > duty) or duty - STEP (target < duty).
  - No wrap-around is possible, since the clamp applies before any overflow or underflow.
- IDLE: duty holds; ticks have no effect.
- en=0: duty, state, busy and cnt all hold; done stays 0.
- Latency: duty and done change on the clock edge at which tick is sampled; busy rises one cycle after accept.
- rst mid-ramp: duty snaps to 0 on the next edge, and any in-flight target is discarded.

Test Plan (CLK_HZ=100, TICK_HZ=10 so DIV=10; STEP=4; en=1 unless stated):
- Reset: assert rst 2 cycles -> duty=0, busy=0, done=0, tgt_ready=0 during rst and 1 after.
- Up ramp: accept tgt=20 from duty=0 -> busy=1 next cycle; duty steps 4,8,12,16,20 at cycles 10,20,30,40,50 after accept; done pulses once with duty=20; busy=0 after.
- Clamp and down ramp:
  - From 0, tgt=10 -> duty 4,8,10 and done.
  - Then tgt=0 -> duty 6,2,0 and done; duty never wraps past 0.
- Full-scale: from duty=0, tgt=255 with STEP=255 -> single tick gives duty=255 and done.
  - Then tgt=0 -> one tick gives duty=0, no underflow.
- Retarget mid-ramp:
  - Ramping 0->40, at duty=12 assert tgt=4 on the same cycle as a tick -> tick dropped, duty stays 12.
  - Subsequent ticks give 8, 4 and done; cnt restarts from 0 at accept.
- Hold and reset: ramp 0->40, drop en for 25 cycles at duty=8 -> duty stays 8, no step.
  - Re-enable -> steps resume with the remaining prescaler count.
  - Assert rst at duty=16 -> duty=0, busy=0 next cycle; tgt=16 equal-duty accept from 16 gives busy=0 and no done.
